// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    localparam logic [MDU_WIDTH-1:0] MDU_DIV0_QUOT = '1;
    localparam logic [MDU_WIDTH-1:0] MDU_OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/mdu_step.sv
// One shift-add multiply or restoring-divide iteration on the 2*WIDTH+1 bit accumulator.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH:0]   trial;

    always_comb begin
        // Multiply: acc = {carry, product high, multiplier/product low}
        sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Divide: acc = {partial remainder (WIDTH+1), dividend/quotient}
        shl   = {acc_in[2*WIDTH-1:0], 1'b0};
        trial = shl[2*WIDTH:WIDTH] - {1'b0, operand};
        acc_out = acc_in >> 1;
        if (is_div)
            acc_out = trial[WIDTH] ? shl : {trial, shl[WIDTH-1:1], 1'b1};
        else if (acc_in[0])
            acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage iterative RV32M multiply/divide sequencer with pipeline stall.
// Build option MDU_EARLY_OUT_EN: finish div-by-zero, overflow and zero-operand multiplies from PREP.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DIV0_QUOT = (WIDTH == MDU_WIDTH) ? WIDTH'(MDU_DIV0_QUOT) : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OVF_QUOT  = (WIDTH == MDU_WIDTH) ? WIDTH'(MDU_OVF_QUOT)
                                                                  : {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state;
    mdu_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q, opnd;
    logic             sign_a, sign_b;
    logic [2*WIDTH:0] acc, acc_next;
    logic [CNT_W-1:0] cnt;

    logic             is_div, sa, sb, div0, ovf;
    logic [WIDTH-1:0] mag_a, mag_b, quot, rem, special_res, fix_res;
    logic [2*WIDTH-1:0] prod;

    assign is_div = op_q[2];
    assign sa     = a_q[WIDTH-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sb     = b_q[WIDTH-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});
    assign mag_a  = sa ? -a_q : a_q;
    assign mag_b  = sb ? -b_q : b_q;
    assign div0   = is_div & (b_q == '0);
    assign ovf    = (op_q inside {OP_DIV, OP_REM}) & (a_q == OVF_QUOT) & (b_q == '1);

    // Corner results are forced from the captured operands, not from the datapath.
    always_comb begin
        special_res = '0;
        if (div0)
            special_res = op_q[1] ? a_q : DIV0_QUOT;
        else if (ovf)
            special_res = op_q[1] ? '0 : OVF_QUOT;
    end

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quot = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                        fix_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_res = quot;
            default:                       fix_res = rem;
        endcase
        if (div0 | ovf)
            fix_res = special_res;
    end

`ifdef MDU_EARLY_OUT_EN
    logic mul_zero;
    assign mul_zero = ~is_div & ((a_q == '0) | (b_q == '0));
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (opnd),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q  <= mdu_op_e'(funct3);
                        a_q   <= src_a;
                        b_q   <= src_b;
                        state <= ST_PREP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    sign_a <= sa;
                    sign_b <= sb;
                    cnt    <= '0;
                    if (is_div) begin
                        acc  <= {{(WIDTH+1){1'b0}}, mag_a};
                        opnd <= mag_b;
                    end else begin
                        acc  <= {{(WIDTH+1){1'b0}}, mag_b};
                        opnd <= mag_a;
                    end
                    state <= ST_CALC;
`ifdef MDU_EARLY_OUT_EN
                    if (div0 | ovf | mul_zero) begin
                        result <= mul_zero ? '0 : special_res;
                        state  <= ST_DONE;
                    end
`endif
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= fix_res;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_PREP) | (state == ST_CALC) | (state == ST_FIX);
    assign done  = (state == ST_DONE);
    assign stall = (start & ~busy & ~done) | busy;

endmodule
